ram_bist_ctrl: RTL and testbench



---
 rtl/ram_bist_ctrl.sv | 133 +++++++++++++
 tb/tb_ram_bist_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: two-pass write/read-back march BIST for a single-port
// synchronous RAM with registered read data. Pass 0 uses the address-derived
// pattern (addr ^ SEED), pass 1 its inverse. Reports pass/fail, the first
// failing address/data and the total mismatch count.
module ram_bist_ctrl #(
   parameter int             DW    = 8,
   parameter int             AW    = 5,
   parameter int             DEPTH = 32,
   parameter logic [DW-1:0]  SEED  = 8'hA5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            mem_wr_re,
   output logic [AW-1:0]   mem_add,
   output logic [DW-1:0]   mem_din,
   input  logic [DW-1:0]   mem_dout,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [AW-1:0]   fail_add,
   output logic [DW-1:0]   fail_data,
   output logic [AW+1:0]   err_cnt
);

   typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

   state_t          state;
   logic            p;          // current pass: 0 = true pattern, 1 = inverted
   logic [AW-1:0]   d_add;      // address aligned with the RAM's registered dout
   logic            chk_vld;    // d_add/mem_dout pair is a read to be checked
   logic            mismatch;
   logic            last_add;
   logic [AW+1:0]   err_next;

   // Pattern written to / expected from address a in pass pp.
   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input logic pp);
      logic [DW-1:0] v;
      v = DW'(a) ^ SEED;
      return pp ? ~v : v;
   endfunction

   // Compare the returning read data against the pattern of the delayed address.
   always_comb begin
      mismatch = chk_vld && (mem_dout != exp_data(d_add, p));
      err_next = err_cnt + (AW+2)'(mismatch);
      last_add = (mem_add == AW'(DEPTH-1));
   end

   // Sequencer, read-latency alignment and result capture, all registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         p         <= 1'b0;
         d_add     <= '0;
         chk_vld   <= 1'b0;
         mem_wr_re <= 1'b0;
         mem_add   <= '0;
         mem_din   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_add  <= '0;
         fail_data <= '0;
         err_cnt   <= '0;
      end else begin
         d_add   <= mem_add;
         chk_vld <= (state == RD);

         if (mismatch) begin
            err_cnt <= err_next;
            if (err_cnt == '0) begin
               fail_add  <= d_add;
               fail_data <= mem_dout;
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  fail_add  <= '0;
                  fail_data <= '0;
                  err_cnt   <= '0;
                  p         <= 1'b0;
                  busy      <= 1'b1;
                  mem_wr_re <= 1'b1;
                  mem_add   <= '0;
                  mem_din   <= exp_data('0, 1'b0);
                  state     <= WR;
               end
            end
            WR: begin
               if (last_add) begin
                  mem_wr_re <= 1'b0;
                  mem_add   <= '0;
                  mem_din   <= '0;
                  state     <= RD;
               end else begin
                  mem_add   <= mem_add + 1'b1;
                  mem_din   <= exp_data(mem_add + 1'b1, p);
               end
            end
            RD: begin
               if (last_add) begin
                  mem_add <= '0;
                  state   <= DRAIN;
               end else begin
                  mem_add <= mem_add + 1'b1;
               end
            end
            DRAIN: begin
               // Final compare of the pass (address DEPTH-1) happens this cycle.
               if (!p) begin
                  p         <= 1'b1;
                  mem_wr_re <= 1'b1;
                  mem_add   <= '0;
                  mem_din   <= exp_data('0, 1'b1);
                  state     <= WR;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural 32x8 RAM with per-address stuck-bit
// masks, plus a pattern-level reference model of the expected BIST result.
module tb_ram_bist_ctrl;
   localparam int DW = 8;
   localparam int AW = 5;
   localparam int DEPTH = 32;
   localparam logic [7:0] SEED = 8'hA5;
   localparam int RUN_LEN = 2 * (2 * DEPTH + 1);

   logic clk = 0, rst = 1, start = 0;
   logic mem_wr_re, busy, done, pass;
   logic [AW-1:0] mem_add, fail_add;
   logic [DW-1:0] mem_din, mem_dout, fail_data;
   logic [AW+1:0] err_cnt;

   logic [7:0] ram [DEPTH];
   logic [7:0] and_m [DEPTH];
   logic [7:0] or_m [DEPTH];

   int n_chk = 0, n_fail = 0;
   int busy_len;
   bit timeout;
   logic       wr_seq  [200];
   logic [7:0] din_seq [200];
   logic [4:0] add_seq [200];

   ram_bist_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_wr_re(mem_wr_re), .mem_add(mem_add), .mem_din(mem_din), .mem_dout(mem_dout),
      .busy(busy), .done(done), .pass(pass),
      .fail_add(fail_add), .fail_data(fail_data), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // RAM: registered read data, stuck bits applied to the cell read-out.
   initial for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
   always @(posedge clk) begin
      if (mem_wr_re) ram[mem_add] <= mem_din;
      mem_dout <= (ram[mem_add] & and_m[mem_add]) | or_m[mem_add];
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic clear_faults();
      for (int i = 0; i < DEPTH; i++) begin
         and_m[i] = 8'hFF;
         or_m[i]  = 8'h00;
      end
   endtask

   // Pulse start, then record the bus every busy cycle; extra starts at s0/s1.
   task automatic do_run(input int s0, input int s1);
      int c;
      c = 0;
      timeout = 0;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      while (busy === 1'b1 && c < 200) begin
         wr_seq[c]  = mem_wr_re;
         din_seq[c] = mem_din;
         add_seq[c] = mem_add;
         start = (c == s0 || c == s1);
         @(negedge clk);
         c++;
      end
      start = 0;
      busy_len = c;
      if (c >= 200) timeout = 1;
   endtask

   // Reference: what each pass reads back from the faulty RAM vs. the pattern.
   task automatic model(output int cnt, output logic [4:0] fa, output logic [7:0] fd);
      logic [7:0] e, got;
      cnt = 0; fa = 0; fd = 0;
      for (int pp = 0; pp < 2; pp++)
         for (int a = 0; a < DEPTH; a++) begin
            e = SEED ^ 8'(a);
            if (pp == 1) e = ~e;
            got = (e & and_m[a]) | or_m[a];
            if (got != e) begin
               if (cnt == 0) begin fa = 5'(a); fd = got; end
               cnt++;
            end
         end
   endtask

   task automatic test_reset();
      rst = 1;
      clear_faults();
      repeat (2) @(negedge clk);
      n_chk++;
      if ({mem_wr_re, mem_add, mem_din} !== '0) begin
         n_fail++; $display("FAIL reset_mem: got %b/%h/%h expected 0/00/00", mem_wr_re, mem_add, mem_din);
      end
      n_chk++;
      if ({busy, done, pass, fail_add, fail_data, err_cnt} !== '0) begin
         n_fail++; $display("FAIL reset_status: got busy=%b done=%b pass=%b fa=%h fd=%h ec=%0d expected all 0",
                            busy, done, pass, fail_add, fail_data, err_cnt);
      end
      rst = 0;
      @(negedge clk);
   endtask

   task automatic test_clean_run();
      clear_faults();
      do_run(-1, -1);
      n_chk++;
      if (timeout || busy_len != RUN_LEN) begin
         n_fail++; $display("FAIL clean_busy_len: got %0d expected %0d", busy_len, RUN_LEN);
      end
      n_chk++;
      if ({done, pass, err_cnt} !== {1'b1, 1'b1, 7'd0}) begin
         n_fail++; $display("FAIL clean_result: got done=%b pass=%b ec=%0d expected 1 1 0", done, pass, err_cnt);
      end
      @(negedge clk);
      n_chk++;
      if ({done, mem_wr_re, mem_add, mem_din} !== {1'b1, 1'b0, 5'd0, 8'd0}) begin
         n_fail++; $display("FAIL idle_hold: got done=%b wr=%b add=%h din=%h expected 1 0 00 00",
                            done, mem_wr_re, mem_add, mem_din);
      end
   endtask

   task automatic test_patterns();
      int w0, w1, bad_add, bad_din;
      logic [7:0] e;
      clear_faults();
      do_run(-1, -1);
      n_chk++;
      if ({din_seq[0], din_seq[7], din_seq[65], din_seq[72]} !== {8'hA5, 8'hA2, 8'h5A, 8'h5D}) begin
         n_fail++; $display("FAIL pattern_points: got %h %h %h %h expected a5 a2 5a 5d",
                            din_seq[0], din_seq[7], din_seq[65], din_seq[72]);
      end
      w0 = 0; w1 = 0; bad_add = 0; bad_din = 0;
      for (int c = 0; c < RUN_LEN; c++) begin
         int i;
         i = c % 65;
         if (wr_seq[c] !== ((i < 32) ? 1'b1 : 1'b0)) begin
            if (c < 65) w0++; else w1++;
         end
         if (add_seq[c] !== ((i < 32) ? 5'(i) : (i < 64) ? 5'(i - 32) : 5'd0)) bad_add++;
         if (i < 32) begin
            e = SEED ^ 8'(i);
            if (c >= 65) e = ~e;
            if (din_seq[c] !== e) bad_din++;
         end
      end
      n_chk++;
      if (w0 != 0 || w1 != 0) begin
         n_fail++; $display("FAIL wr_re_shape: got %0d/%0d bad cycles expected 0/0", w0, w1);
      end
      n_chk++;
      if (bad_add != 0) begin
         n_fail++; $display("FAIL add_sequence: got %0d bad cycles expected 0", bad_add);
      end
      n_chk++;
      if (bad_din != 0) begin
         n_fail++; $display("FAIL din_sequence: got %0d bad writes expected 0", bad_din);
      end
   endtask

   task automatic test_stuck0();
      clear_faults();
      and_m[7] = 8'hFE;
      do_run(-1, -1);
      n_chk++;
      if ({done, pass, err_cnt, fail_add, fail_data} !== {1'b1, 1'b0, 7'd1, 5'd7, 8'h5C}) begin
         n_fail++; $display("FAIL stuck0: got done=%b pass=%b ec=%0d fa=%0d fd=%h expected 1 0 1 7 5c",
                            done, pass, err_cnt, fail_add, fail_data);
      end
   endtask

   task automatic test_stuck1();
      clear_faults();
      or_m[3] = 8'h80;
      or_m[20] = 8'h80;
      do_run(-1, -1);
      n_chk++;
      if ({done, pass, err_cnt, fail_add, fail_data} !== {1'b1, 1'b0, 7'd2, 5'd3, 8'hD9}) begin
         n_fail++; $display("FAIL stuck1: got done=%b pass=%b ec=%0d fa=%0d fd=%h expected 1 0 2 3 d9",
                            done, pass, err_cnt, fail_add, fail_data);
      end
   endtask

   task automatic test_start_ignored();
      clear_faults();
      do_run(10, 60);
      n_chk++;
      if (timeout || busy_len != RUN_LEN) begin
         n_fail++; $display("FAIL start_ignored_len: got %0d expected %0d", busy_len, RUN_LEN);
      end
      n_chk++;
      if ({done, pass, err_cnt} !== {1'b1, 1'b1, 7'd0}) begin
         n_fail++; $display("FAIL start_ignored_result: got done=%b pass=%b ec=%0d expected 1 1 0", done, pass, err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      clear_faults();
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      repeat (40) @(negedge clk);
      rst = 1;
      #1;
      n_chk++;
      if ({mem_wr_re, mem_add, mem_din, busy, done, pass, fail_add, fail_data, err_cnt} !== '0) begin
         n_fail++; $display("FAIL reset_mid_async: got wr=%b add=%h din=%h busy=%b done=%b expected all 0",
                            mem_wr_re, mem_add, mem_din, busy, done);
      end
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      n_chk++;
      if ({busy, mem_wr_re} !== 2'b00) begin
         n_fail++; $display("FAIL reset_mid_idle: got busy=%b wr=%b expected 0 0", busy, mem_wr_re);
      end
      do_run(-1, -1);
      n_chk++;
      if (timeout || busy_len != RUN_LEN || {done, pass, err_cnt} !== {1'b1, 1'b1, 7'd0}) begin
         n_fail++; $display("FAIL reset_mid_rerun: got len=%0d done=%b pass=%b ec=%0d expected %0d 1 1 0",
                            busy_len, done, pass, err_cnt, RUN_LEN);
      end
   endtask

   task automatic test_random_faults();
      int ecnt, k;
      logic [4:0] efa;
      logic [7:0] efd, bitm;
      for (int it = 0; it < 6; it++) begin
         clear_faults();
         k = (it == 5) ? 40 : $urandom_range(0, 4);
         for (int f = 0; f < k; f++) begin
            int a;
            a = $urandom_range(0, DEPTH - 1);
            bitm = 8'h01 << $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) or_m[a] = or_m[a] | bitm;
            else and_m[a] = and_m[a] & ~bitm;
         end
         model(ecnt, efa, efd);
         do_run(-1, -1);
         n_chk++;
         if (timeout || busy_len != RUN_LEN) begin
            n_fail++; $display("FAIL rand%0d_len: got %0d expected %0d", it, busy_len, RUN_LEN);
         end
         n_chk++;
         if ({done, pass, err_cnt} !== {1'b1, (ecnt == 0), 7'(ecnt)}) begin
            n_fail++; $display("FAIL rand%0d_result: got done=%b pass=%b ec=%0d expected 1 %b %0d",
                               it, done, pass, err_cnt, (ecnt == 0), ecnt);
         end
         n_chk++;
         if ({fail_add, fail_data} !== {efa, efd}) begin
            n_fail++; $display("FAIL rand%0d_first: got fa=%0d fd=%h expected %0d %h", it, fail_add, fail_data, efa, efd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_patterns();
      test_stuck0();
      test_stuck1();
      test_start_ignored();
      test_reset_mid();
      test_random_faults();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
